// File: rtl/proc_controller_if.sv
// Control-unit bus bundle between proc_controller and the rest of the processor.
//   master: the controller. It receives instr from the instruction ROM and drives
//           the ROM address, debug state, data-memory and register-file controls.
//   slave:  the ROM/datapath side, or a testbench.
// Signals:
//   instr       ROM data, combinational from pc_out
//   pc_out      ROM address (current PC)
//   ir_out      instruction register
//   state_out   FSM state code, for debug/display
//   d_addr      data-memory address, d_wr write strobe
//   rf_s        RF write-data select (1 = data memory, 0 = ALU)
//   rf_w_addr   RF write address, rf_w_en write enable
//   rf_ra_addr  RF read port A address, rf_rb_addr read port B address
//   alu_s0      ALU function select
interface proc_controller_if #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned INSTR_W = 16
);
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc_out;
  logic [INSTR_W-1:0] ir_out;
  logic [3:0]         state_out;
  logic [7:0]         d_addr;
  logic               d_wr;
  logic               rf_s;
  logic [3:0]         rf_w_addr;
  logic               rf_w_en;
  logic [3:0]         rf_ra_addr;
  logic [3:0]         rf_rb_addr;
  logic [2:0]         alu_s0;

  modport master (
    input  instr,
    output pc_out, ir_out, state_out, d_addr, d_wr, rf_s,
    output rf_w_addr, rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0
  );

  modport slave (
    output instr,
    input  pc_out, ir_out, state_out, d_addr, d_wr, rf_s,
    input  rf_w_addr, rf_w_en, rf_ra_addr, rf_rb_addr, alu_s0
  );
endinterface

// File: rtl/proc_controller.sv
// Control unit of the programmable processor. It holds the PC, the IR and the
// instruction FSM, and it drives the ROM address, data-memory and register-file controls
// and the ALU function select. This is a Moore machine: every output is decoded
// from the registered state and the IR only.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset. It forces INIT, PC=0 and IR=0 at once.
//   bus    proc_controller_if.master (see the interface header for the signal list)
module proc_controller #(
  parameter int unsigned PC_W    = 7,
  parameter int unsigned INSTR_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  proc_controller_if.master  bus
);

  // The encoding is visible on state_out, so the values are fixed.
  typedef enum logic [3:0] {
    StInit   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StNoop   = 4'd3,
    StLoadA  = 4'd4,
    StLoadB  = 4'd5,
    StStore  = 4'd6,
    StAdd    = 4'd7,
    StSub    = 4'd8,
    StHalt   = 4'd9
  } state_e;

  localparam logic [3:0] OpNoop  = 4'h0;
  localparam logic [3:0] OpStore = 4'h1;
  localparam logic [3:0] OpLoad  = 4'h2;
  localparam logic [3:0] OpAdd   = 4'h3;
  localparam logic [3:0] OpSub   = 4'h4;
  localparam logic [3:0] OpHalt  = 4'h5;

  localparam logic [2:0] AluPass = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [3:0]         opcode;

  assign opcode = ir_q[15:12];

  // State, PC and IR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Next state. PC and IR are loaded only in FETCH.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      StInit: state_d = StFetch;
      StFetch: begin
        ir_d    = bus.instr;
        pc_d    = pc_q + PC_W'(1);  // wraps modulo 2^PC_W
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OpStore: state_d = StStore;
          OpLoad:  state_d = StLoadA;
          OpAdd:   state_d = StAdd;
          OpSub:   state_d = StSub;
          OpHalt:  state_d = StHalt;
          default: state_d = StNoop;  // NOOP and every unassigned opcode
        endcase
      end
      StLoadA: state_d = StLoadB;     // one wait cycle for the RAM read
      StNoop, StStore, StLoadB, StAdd, StSub: state_d = StFetch;
      StHalt: state_d = StHalt;       // only rst_n leaves HALT
      default: state_d = StInit;
    endcase
  end

  // Address fields follow the IR in every state. Only the strobes qualify them.
  assign bus.pc_out     = pc_q;
  assign bus.ir_out     = ir_q;
  assign bus.state_out  = state_q;
  assign bus.d_addr     = ir_q[11:4];
  assign bus.rf_w_addr  = ir_q[3:0];
  assign bus.rf_rb_addr = ir_q[7:4];
  // STORE reads its source register through port A, from the low nibble.
  assign bus.rf_ra_addr = (opcode == OpStore) ? ir_q[3:0] : ir_q[11:8];

  // Strobes and selects, decoded from state only
  always_comb begin
    bus.d_wr    = 1'b0;
    bus.rf_s    = 1'b0;
    bus.rf_w_en = 1'b0;
    bus.alu_s0  = AluPass;
    case (state_q)
      StLoadA: bus.rf_s = 1'b1;
      StLoadB: begin
        bus.rf_s    = 1'b1;
        bus.rf_w_en = 1'b1;
      end
      StStore: bus.d_wr = 1'b1;
      StAdd: begin
        bus.alu_s0  = AluAdd;
        bus.rf_w_en = 1'b1;
      end
      StSub: begin
        bus.alu_s0  = AluSub;
        bus.rf_w_en = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_controller.sv
// Bench for proc_controller. A ROM array feeds instr combinationally from pc_out.
module tb_proc_controller;

  localparam int unsigned PC_W = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] rom [128];
  int          checks = 0;
  int          errors = 0;

  proc_controller_if #(.PC_W(PC_W), .INSTR_W(16)) bus ();
  assign bus.instr = rom[bus.pc_out];

  proc_controller #(.PC_W(PC_W), .INSTR_W(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  st;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [7:0]  da;
    logic        dwr;
    logic        rfs;
    logic [3:0]  wa;
    logic        wen;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
  } obs_t;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  st;
    logic [7:0]  da;
    logic        dwr;
    logic        rfs;
    logic [3:0]  wa;
    logic        wen;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [2:0]  alu;
    bit          chk_ra;
    bit          chk_rb;
  } vec_t;

  // Reference model: the architectural PC and IR at instruction granularity
  logic [6:0]  m_pc;
  logic [15:0] m_ir;

  function automatic obs_t sample();
    obs_t o;
    o.st  = bus.state_out;
    o.pc  = bus.pc_out;
    o.ir  = bus.ir_out;
    o.da  = bus.d_addr;
    o.dwr = bus.d_wr;
    o.rfs = bus.rf_s;
    o.wa  = bus.rf_w_addr;
    o.wen = bus.rf_w_en;
    o.ra  = bus.rf_ra_addr;
    o.rb  = bus.rf_rb_addr;
    o.alu = bus.alu_s0;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("st=%0d pc=%0d ir=%h da=%h dwr=%b rfs=%b wa=%h wen=%b ra=%h rb=%h alu=%b",
                     o.st, o.pc, o.ir, o.da, o.dwr, o.rfs, o.wa, o.wen, o.ra, o.rb, o.alu);
  endfunction

  function automatic obs_t mask_fn(input bit chk_ra, input bit chk_rb);
    obs_t m;
    m    = '1;
    m.ra = chk_ra ? 4'hF : 4'h0;
    m.rb = chk_rb ? 4'hF : 4'h0;
    return m;
  endfunction

  // Quiet-cycle expectation: no strobes, and the address fields taken from the model IR
  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o    = '0;
    o.st = st;
    o.pc = m_pc;
    o.ir = m_ir;
    o.da = m_ir[11:4];
    o.wa = m_ir[3:0];
    return o;
  endfunction

  task automatic check(input string name, input obs_t exp, input obs_t mask);
    obs_t act;
    act = sample();
    checks++;
    if (((act ^ exp) & mask) !== '0) begin
      errors++;
      $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Assert reset in whatever state the DUT is in, check that it takes effect at once,
  // and leave the DUT in FETCH.
  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    m_pc = '0;
    m_ir = '0;
    check(name, base(4'd0), mask_fn(0, 0));
    step();
    check({name, "_held"}, base(4'd0), mask_fn(0, 0));
    rst_n = 1'b1;
    step();
  endtask

  // Run one instruction through the model and check each cycle, starting in FETCH
  task automatic run_instr(output bit halted);
    obs_t e;
    halted = 1'b0;
    check("fetch", base(4'd1), mask_fn(0, 0));
    step();
    m_ir = rom[m_pc];
    m_pc = m_pc + 7'd1;
    check("decode", base(4'd2), mask_fn(0, 0));
    step();
    case (m_ir[15:12])
      4'h1: begin
        e = base(4'd6); e.dwr = 1'b1; e.ra = m_ir[3:0];
        check("store", e, mask_fn(1, 0));
        step();
      end
      4'h2: begin
        e = base(4'd4); e.rfs = 1'b1;
        check("load_a", e, mask_fn(0, 0));
        step();
        e = base(4'd5); e.rfs = 1'b1; e.wen = 1'b1;
        check("load_b", e, mask_fn(0, 0));
        step();
      end
      4'h3, 4'h4: begin
        e = base(m_ir[15:12] == 4'h3 ? 4'd7 : 4'd8);
        e.alu = (m_ir[15:12] == 4'h3) ? 3'b001 : 3'b010;
        e.wen = 1'b1; e.ra = m_ir[11:8]; e.rb = m_ir[7:4];
        check("alu_op", e, mask_fn(1, 1));
        step();
      end
      4'h5: begin
        check("halt", base(4'd9), mask_fn(0, 0));
        halted = 1'b1;
      end
      default: begin
        check("noop", base(4'd3), mask_fn(0, 0));
        step();
      end
    endcase
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'h5) op = 4'h0;
    return {op, 12'($urandom)};
  endfunction

  vec_t tbl [8];

  initial begin
    obs_t e;
    bit   halted;
    int   n;

    tbl[0] = '{16'h2053, 4'd5, 8'h05, 1'b0, 1'b1, 4'h3, 1'b1, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};
    tbl[1] = '{16'h3124, 4'd7, 8'h12, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b001, 1'b1, 1'b1};
    tbl[2] = '{16'h4124, 4'd8, 8'h12, 1'b0, 1'b0, 4'h4, 1'b1, 4'h1, 4'h2, 3'b010, 1'b1, 1'b1};
    tbl[3] = '{16'h10A7, 4'd6, 8'h0A, 1'b1, 1'b0, 4'h7, 1'b0, 4'h7, 4'h0, 3'b000, 1'b1, 1'b0};
    tbl[4] = '{16'hF0FF, 4'd3, 8'h0F, 1'b0, 1'b0, 4'hF, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};
    tbl[5] = '{16'h0000, 4'd3, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};
    tbl[6] = '{16'h6ABC, 4'd3, 8'hAB, 1'b0, 1'b0, 4'hC, 1'b0, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};
    tbl[7] = '{16'h2F0E, 4'd5, 8'hF0, 1'b0, 1'b1, 4'hE, 1'b1, 4'h0, 4'h0, 3'b000, 1'b0, 1'b0};

    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    for (int i = 0; i < 8; i++) rom[i] = tbl[i].instr;
    #3;

    // Table vectors: constant expectations for the final execute cycle of each instruction
    do_reset("reset");
    for (int i = 0; i < 8; i++) begin
      m_pc = 7'(i); m_ir = (i == 0) ? 16'h0000 : tbl[i-1].instr;
      check("tbl_fetch", base(4'd1), mask_fn(0, 0));
      step();
      m_pc = 7'(i + 1); m_ir = tbl[i].instr;
      check("tbl_decode", base(4'd2), mask_fn(0, 0));
      step();
      if (tbl[i].st == 4'd5) begin
        e = base(4'd4); e.rfs = 1'b1;
        check("tbl_load_a", e, mask_fn(0, 0));
        step();
      end
      e = '{st: tbl[i].st, pc: 7'(i + 1), ir: tbl[i].instr, da: tbl[i].da, dwr: tbl[i].dwr,
            rfs: tbl[i].rfs, wa: tbl[i].wa, wen: tbl[i].wen, ra: tbl[i].ra, rb: tbl[i].rb,
            alu: tbl[i].alu};
      check($sformatf("tbl_exec_%0d", i), e, mask_fn(tbl[i].chk_ra, tbl[i].chk_rb));
      step();
    end

    // Random program without HALT. 150 instructions take the PC past 127 and back to 0.
    for (int i = 0; i < 128; i++) rom[i] = rand_instr();
    rom[127] = 16'h0000;
    do_reset("reset_rand");
    for (int i = 0; i < 150; i++) begin
      run_instr(halted);
      if (halted) begin
        checks++; errors++;
        $display("FAIL rand_unexpected_halt: got halt at pc %0d, want no halt", m_pc);
        break;
      end
    end

    // HALT at ROM[126]: PC is held at 127 with no strobes, and only reset leaves HALT
    for (int i = 0; i < 128; i++) rom[i] = rand_instr();
    rom[126] = 16'h5000;
    do_reset("reset_halt");
    n = 0;
    halted = 1'b0;
    while (!halted && n < 140) begin
      run_instr(halted);
      n++;
    end
    checks++;
    if (!halted || m_pc != 7'd127) begin
      errors++;
      $display("FAIL halt_reached: got halted=%0d pc=%0d, want halted=1 pc=127", halted, m_pc);
    end
    for (int i = 0; i < 22; i++) begin
      step();
      check("halt_hold", base(4'd9), mask_fn(0, 0));
    end
    do_reset("reset_from_halt");

    // Reset during LOAD_A: strobes drop at once, and no RF write follows
    rom[0] = 16'h2053;
    do_reset("reset_pre_load");
    step();
    step();
    m_pc = 7'd1; m_ir = 16'h2053;
    e = base(4'd4); e.rfs = 1'b1;
    check("pre_reset_load_a", e, mask_fn(0, 0));
    do_reset("reset_in_load_a");

    // Reset during STORE: d_wr drops in the same cycle
    rom[0] = 16'h10A7;
    do_reset("reset_pre_store");
    step();
    step();
    m_pc = 7'd1; m_ir = 16'h10A7;
    e = base(4'd6); e.dwr = 1'b1; e.ra = 4'h7;
    check("pre_reset_store", e, mask_fn(1, 0));
    do_reset("reset_in_store");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
